// File: rtl/iot_frame_ctrl_pkg.sv
// Shared types and constants for the IoT frame controller and its filter blocks.
// No logic; encodings only.
// State codes are one-hot-ish and visible on the filter sideband.
package iot_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_LOAD = 3'b001,
        ST_CMP  = 3'b010,
        ST_DONE = 3'b100
    } state_e;

    localparam int FRAME_BYTES = 16;

    // Function codes decoded by the filterN blocks from fn_sel_q.
    localparam logic [2:0] FN_MAX = 3'b110;

endpackage

// File: rtl/iot_frame_ctrl_if.sv
// Byte-stream input and frame sideband between host, controller and filters.
// Pure wiring bundle, no latency.
// busy is the only flow-control signal; the host must hold off in_en while it is high.
interface iot_frame_if;
    logic         in_en;
    logic [7:0]   iot_in;
    logic [2:0]   fn_sel;
    logic [2:0]   fn_sel_q;
    logic [127:0] data;
    logic [5:0]   cnt;
    logic [2:0]   state;
    logic         flag;
    logic         valid;
    logic [7:0]   cycle_cnt;
    logic         busy;
    logic         drop_err;

    // Host side: offers bytes, observes the frame sideband.
    modport master (
        output in_en, iot_in, fn_sel,
        input  fn_sel_q, data, cnt, state, flag, valid, cycle_cnt, busy, drop_err
    );

    // Controller side.
    modport slave (
        input  in_en, iot_in, fn_sel,
        output fn_sel_q, data, cnt, state, flag, valid, cycle_cnt, busy, drop_err
    );
endinterface

// File: rtl/iot_byte_shifter.sv
// 128-bit byte shift register with accepted-byte counter.
// One cycle: shifted data and count visible after the enabling edge.
// No backpressure; the caller only asserts shift_en_i when a byte is accepted.
module iot_byte_shifter (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en_i,
    input  logic         cnt_clr_i,
    input  logic [7:0]   byte_i,
    output logic [127:0] data_o,
    output logic [5:0]   cnt_o
);
    logic [127:0] data_q;
    logic [5:0]   cnt_q;

    // Shift new bytes in at the LSB end; clear only drops the count so data stays stable for the filters.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (shift_en_i) begin
            data_q <= {data_q[119:0], byte_i};
            cnt_q  <= cnt_q + 6'd1;
        end else if (cnt_clr_i) begin
            cnt_q  <= '0;
        end
    end

    assign data_o = data_q;
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/iot_frame_ctrl.sv
// Frames the 8-bit IoT byte stream into 128-bit words and drives the filter sideband.
// Registered outputs; CMP follows the 16th byte edge, DONE one cycle after the last CMP.
// busy high in CMP/DONE; bytes offered then are dropped and latch drop_err.
module iot_frame_ctrl
    import iot_frame_ctrl_pkg::*;
#(
    parameter int NUM_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    iot_frame_if.slave bus
);
    localparam logic [7:0] LAST_FRAME = 8'(NUM_FRAMES);
    localparam logic [5:0] LAST_BYTE  = 6'(FRAME_BYTES - 1);

    state_e     state_q, state_d;
    logic [7:0] cyc_q, cyc_d;
    logic       flag_q, flag_d;
    logic       valid_q, valid_d;
    logic       drop_q, drop_d;
    logic [2:0] fn_q, fn_d;
    logic       shift_en;
    logic       cnt_clr;
    logic       busy;
    logic [5:0] cnt;
    logic [127:0] data;

    assign busy = (state_q == ST_CMP) || (state_q == ST_DONE);

    iot_byte_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (shift_en),
        .cnt_clr_i  (cnt_clr),
        .byte_i     (bus.iot_in),
        .data_o     (data),
        .cnt_o      (cnt)
    );

    // Next-state, batch counters and sideband decisions.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        flag_d   = flag_q;
        valid_d  = 1'b0;
        fn_d     = fn_q;
        shift_en = 1'b0;
        cnt_clr  = 1'b0;
        drop_d   = drop_q | (bus.in_en & busy);
        case (state_q)
            ST_IDLE: begin
                if (bus.in_en) begin
                    shift_en = 1'b1;
                    fn_d     = bus.fn_sel;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.in_en) begin
                    shift_en = 1'b1;
                    if (cnt == LAST_BYTE) state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                cnt_clr = 1'b1;
                cyc_d   = cyc_q + 8'd1;
                flag_d  = 1'b1;
                if (cyc_q + 8'd1 == LAST_FRAME) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                flag_d  = 1'b0;
                cyc_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and sideband registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            flag_q  <= 1'b0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            fn_q    <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            flag_q  <= flag_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            fn_q    <= fn_d;
        end
    end

    assign bus.fn_sel_q  = fn_q;
    assign bus.data      = data;
    assign bus.cnt       = cnt;
    assign bus.state     = state_q;
    assign bus.flag      = flag_q;
    assign bus.valid     = valid_q;
    assign bus.cycle_cnt = cyc_q;
    assign bus.busy      = busy;
    assign bus.drop_err  = drop_q;
endmodule

// File: doc/iot_frame_ctrl.md
# iot_frame_ctrl

Front-end controller that turns the 8-bit IoT input byte stream into framed 128-bit words and the control sideband used by the filter blocks: `data`, `cnt`, `state`, `flag`, `valid` and `cycle_cnt`. It sits between the input pins and all `filterN` instances, and acts as the initiator side of the filter interface. It assembles 16 bytes per frame, holds one compare cycle per frame, and closes a batch after `NUM_FRAMES` frames.

## Interface
- `NUM_FRAMES`, default 8: frames per batch; legal range 1..255.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_en` input 1: byte strobe; `iot_in` is valid this cycle.
- `iot_in` input 8: input byte; the first byte of a frame ends up in `data[127:120]`.
- `fn_sel` input 3: function select from host; sampled only at batch start.
- `fn_sel_q` output 3: latched function select; drives the filters for the whole batch.
- `data` output 128: assembled frame shift register.
- `cnt` output 6: bytes accepted in the current frame, 0..16.
- `state` output 3: FSM state encoding.
- `flag` output 1: 0 during the first frame of a batch, 1 afterwards.
- `valid` output 1: one-cycle pulse when a batch completes.
- `cycle_cnt` output 8: frames completed in the current batch.
- `busy` output 1: upstream must not drive `in_en` while this is high.
- `drop_err` output 1: sticky; set when a byte is offered while `busy` is high.

## Operation
- **Reset values:** all outputs are 0, and `state` = IDLE.
- **States:**
  - IDLE = 3'b000
  - LOAD = 3'b001
  - CMP = 3'b010
  - DONE = 3'b100
- **Byte accept:** a byte is accepted when `in_en` = 1 and `state` is IDLE or LOAD.
  - `data` <= {`data[119:0]`, `iot_in`}.
  - `cnt` <= `cnt` + 1.
- **IDLE:**
  - On an accepted byte: `fn_sel_q` <= `fn_sel`, `state` -> LOAD, `cnt` -> 1.
  - Otherwise the state holds.
- **LOAD:**
  - If the accepted byte makes `cnt` = 16, `state` -> CMP.
  - Cycles with `in_en` = 0 hold `cnt` and `data`; gaps between bytes are unlimited.
- **CMP:**
  - Lasts exactly one cycle, with `cnt` = 16 and `data` stable. This is the cycle in which the filters evaluate.
  - On exit: `cnt` <= 0, `cycle_cnt` <= `cycle_cnt` + 1, `flag` <= 1.
  - Next state is DONE if `cycle_cnt` + 1 == `NUM_FRAMES`, else LOAD.
- **DONE:**
  - Lasts one cycle with `valid` = 1.
  - On exit: `state` -> IDLE, `flag` <= 0, `cycle_cnt` <= 0.
  - `data` and `fn_sel_q` keep their values until the next batch.
- **Busy and drops:**
  - `busy` = 1 in CMP and DONE.
  - A byte offered while busy is discarded and sets `drop_err` = 1. `drop_err` clears only on `rst`.
- **`fn_sel` changes** outside IDLE have no effect until the next batch.
- **Arithmetic:** `cycle_cnt` cannot wrap, because `NUM_FRAMES` ≤ 255. `cnt` never exceeds 16.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- From the 16th accepted byte at edge N, the outputs are:
  - at N: `state` = CMP, `cnt` = 16, `data` complete;
  - at N+1: `cnt` = 0, and `state` = LOAD or DONE;
  - at N+2 (after the final frame only): `state` = IDLE.
- Minimum frame period is 17 cycles: 16 bytes plus 1 CMP cycle. The final frame of a batch takes 18 cycles because of the DONE cycle.
- In the CMP cycle, `flag` still shows its pre-increment value. It is 0 for frame 0 of a batch, so a filter sees `flag` = 0 together with `state` = CMP exactly once per batch.
- `rst` asserted in any state, including mid-frame, returns every register to its reset value at the next edge. The partial frame is discarded.
- `in_en` asserted on the same cycle as `rst` is ignored.

## Structure
- The shared package holds:
  - the state encodings (IDLE, LOAD, CMP, DONE);
  - `FRAME_BYTES` = 16;
  - the `fn_sel` function codes (3'b110 = max, etc.), which are also used by the `filterN` blocks.
- One sub-module, `iot_byte_shifter`: the 128-bit shift register and `cnt`, with load enable and clear.
- The FSM, frame/batch counters, `flag`, `valid` and `drop_err` stay in the top level.

## Test plan
- **Reset:** assert `rst` for 2 cycles, then release.
  - All outputs must be 0 and `state` = 3'b000.
- **Single frame:** bytes 0x01..0x10 on 16 consecutive cycles, `fn_sel` = 3'b110, `NUM_FRAMES` = 2.
  - Next cycle: `data` = 0x0102030405060708090A0B0C0D0E0F10, `cnt` = 16, `state` = 3'b010, `flag` = 0, `fn_sel_q` = 3'b110.
  - Following cycle: `cnt` = 0, `cycle_cnt` = 1, `flag` = 1.
- **Batch end:** complete the second frame of that batch.
  - CMP is shown with `flag` = 1.
  - Then `state` = 3'b100 with `valid` = 1 for exactly one cycle.
  - Then IDLE with `flag` = 0 and `cycle_cnt` = 0.
- **Gapped input:** 16 bytes with `in_en` high every third cycle.
  - `cnt` holds between strobes, and CMP is entered only after the 16th byte.
- **Busy violation:** drive `in_en` with byte 0xAA during CMP.
  - `data` is unchanged, `cnt` goes to 0 and `drop_err` = 1.
  - `drop_err` stays 1 until `rst`.
- **Mid-frame reset:** assert `rst` after 7 bytes.
  - `cnt` = 0, `data` = 0, IDLE.
  - A fresh 16-byte frame then completes normally with `flag` = 0.
